// File: rtl/load_store_unit.sv
// Load/store unit: aligns, extends and merges sub-word accesses onto a 32-bit word memory.
// Optional macro LSU_MISALIGN_TRAP_EN reports misaligned accesses as errors instead of forcing alignment.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {IDLE, LOAD, ST_RD, ST_WR, RESP} state_e;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misaligned;
    logic [31:0] req_addr;
    logic [31:0] lane_shifted;
    logic [31:0] lane_mask;
    logic [31:0] load_value;
    logic [4:0]  lane_shift;

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q, err_d;

    always_comb begin
        misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
        req_addr   = addr;
    end
`else
    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b00:   req_addr = addr;
            2'b01:   req_addr = {addr[31:1], 1'b0};
            default: req_addr = {addr[31:2], 2'b00};
        endcase
    end
`endif

    // Byte-lane datapath shared by load extraction and store merge.
    always_comb begin
        lane_shift   = {addr_q[1:0], 3'b000};
        lane_shifted = mem_rd >> lane_shift;
        lane_mask    = ((size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << lane_shift;
        case (size_q)
            2'b00:   load_value = {{24{~uns_q & lane_shifted[7]}}, lane_shifted[7:0]};
            2'b01:   load_value = {{16{~uns_q & lane_shifted[15]}}, lane_shifted[15:0]};
            default: load_value = mem_rd;
        endcase
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d  = state_q;
        wr_d     = wr_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merged_d = merged_q;
        rdata_d  = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d    = err_q;
`endif
        ready    = 1'b0;
        done     = 1'b0;
        mem_a    = 32'h0;
        mem_we   = 1'b0;
        mem_wd   = 32'h0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    wr_d    = wr;
                    size_d  = size;
                    uns_d   = uns;
                    addr_d  = req_addr;
                    wdata_d = wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                    err_d   = misaligned;
`endif
                    if (misaligned)  state_d = RESP;
                    else if (!wr)    state_d = LOAD;
                    else if (size[1]) state_d = ST_WR;
                    else             state_d = ST_RD;
                end
            end
            LOAD: begin
                mem_a = {addr_q[31:2], 2'b00};
                if (!wr_q) rdata_d = load_value;
                state_d = RESP;
            end
            ST_RD: begin
                mem_a    = {addr_q[31:2], 2'b00};
                merged_d = (mem_rd & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
                state_d  = ST_WR;
            end
            ST_WR: begin
                mem_a   = {addr_q[31:2], 2'b00};
                mem_we  = 1'b1;
                mem_wd  = size_q[1] ? wdata_q : merged_q;
                state_d = RESP;
            end
            RESP: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            merged_q <= 32'h0;
            rdata_q  <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q  <= state_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q    <= err_d;
`endif
        end
    end

    assign rdata = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign err = done & err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level memory model.
// Works with or without LSU_MISALIGN_TRAP_EN defined.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready, done, err;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] dut_mem [16];
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rdata = 32'h0;
    int          we_count = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
        .rdata(rdata), .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = dut_mem[mem_a[5:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            dut_mem[mem_a[5:2]] <= mem_wd;
            we_count <= we_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [7:0] ref_byte(input int a);
        logic [31:0] w;
        w = ref_mem[(a / 4) % 16];
        return w[8 * (a % 4) +: 8];
    endfunction

    task automatic ref_set_byte(input int a, input logic [7:0] v);
        logic [31:0] w;
        w = ref_mem[(a / 4) % 16];
        w[8 * (a % 4) +: 8] = v;
        ref_mem[(a / 4) % 16] = w;
    endtask

    // One transaction: REQ is held until DONE so busy-cycle requests are exercised.
    task automatic do_op(input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        int n, ea, cycles, we_before;
        bit mis;
        logic [31:0] v;
        n  = nbytes(s);
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (int'(a) % n) != 0;
        ea  = int'(a);
`else
        mis = 1'b0;
        ea  = int'(a) - (int'(a) % n);
`endif
        @(negedge clk);
        check("idle_ready", {31'b0, ready}, 32'd1);
        check("idle_mem_a", mem_a, 32'h0);
        wr = w; size = s; uns = u; addr = a; wdata = d; req = 1'b1;
        we_before = we_count;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (mem_a[1:0] != 2'b00) check("mem_a_align", mem_a, {mem_a[31:2], 2'b00});
        end while (!done && cycles < 10);
        req = 1'b0;

        check("latency", cycles, mis ? 1 : (!w || n == 4) ? 2 : 3);
        check("err", {31'b0, err}, {31'b0, mis});

        if (!mis && !w) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8 * i +: 8] = ref_byte(ea + i);
            if (n < 4 && !u && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 1);
            exp_rdata = v;
        end
        if (!mis && w) begin
            for (int i = 0; i < n; i++) ref_set_byte(ea + i, d[8 * i +: 8]);
        end
        check("rdata", rdata, exp_rdata);
        check("we_pulses", we_count - we_before, (!mis && w) ? 1 : 0);
        check("mem_word", dut_mem[(int'(a) / 4) % 16], ref_mem[(int'(a) / 4) % 16]);
    endtask

    initial begin
        logic [31:0] r;
        for (int i = 0; i < 16; i++) begin
            r = (i == 0) ? 32'hface_face : $urandom;
            dut_mem[i] <= r;
            ref_mem[i] = r;
        end
        #1;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(1'b0, 2'b00, 1'b0, 32'h3, 32'h0);
        check("lb_fixed", rdata, 32'hffff_fffa);
        do_op(1'b0, 2'b00, 1'b1, 32'h3, 32'h0);
        check("lbu_fixed", rdata, 32'h0000_00fa);
        do_op(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
        check("lh_fixed", rdata, 32'hffff_face);
        do_op(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
        check("lhu_fixed", rdata, 32'h0000_face);
        do_op(1'b1, 2'b00, 1'b0, 32'h1, 32'h0000_0055);
        check("sb_fixed", dut_mem[0], 32'hface_55ce);
        do_op(1'b1, 2'b10, 1'b0, 32'h8, 32'h1234_5678);
        check("sw_fixed", dut_mem[2], 32'h1234_5678);
        do_op(1'b1, 2'b01, 1'b0, 32'h1, 32'h0000_beef);
`ifdef LSU_MISALIGN_TRAP_EN
        check("sh_mis_fixed", dut_mem[0], 32'hface_55ce);
`else
        check("sh_mis_fixed", dut_mem[0], 32'hface_beef);
`endif

        // Reset while the sub-word store sits in its read phase.
        @(negedge clk);
        wr = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h4; wdata = 32'h0000_00aa; req = 1'b1;
        r = we_count;
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b0;
        exp_rdata = 32'h0;
        #1;
        check("abort_mem_we", {31'b0, mem_we}, 32'd0);
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_rdata", rdata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_we_pulses", we_count - int'(r), 32'd0);
        check("abort_mem1", dut_mem[1], ref_mem[1]);

        for (int k = 0; k < 300; k++) begin
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 63)), $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        for (int i = 0; i < 16; i++) check("final_mem", dut_mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
